// File: rtl/timer_dev_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_defs (package)
//  Description : Register map, CTRL layout, mode codes and FSM states shared
//                by the countdown timer.
//  Revision    : 1.0
// ============================================================================
package timer_defs;

    localparam logic [1:0] c_ADDR_CTRL   = 2'd0;
    localparam logic [1:0] c_ADDR_PRESET = 2'd1;
    localparam logic [1:0] c_ADDR_COUNT  = 2'd2;

    localparam int c_BIT_EN      = 0;
    localparam int c_BIT_MODE_LO = 1;
    localparam int c_BIT_MODE_HI = 2;
    localparam int c_BIT_IM      = 3;
    localparam int c_CTRL_W      = 4;

    localparam logic [1:0] c_MODE_ONESHOT = 2'b00;
    localparam logic [1:0] c_MODE_AUTO    = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    // Packed so that the field order matches the CTRL bit positions.
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    function automatic logic [31:0] ctrl_view(input ctrl_t c);
        return {{(32 - c_CTRL_W){1'b0}}, c};
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_dev.sv
`default_nettype none
// ============================================================================
//  Module      : timer_dev
//  Description : Memory-mapped programmable countdown timer with one-shot and
//                auto-reload modes and a maskable level interrupt.
//  Revision    : 1.0
// ============================================================================
module timer_dev
    import timer_defs::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        IRQ
);

    ctrl_t       r_ctrl_q;
    ctrl_t       w_ctrl_d;
    logic [31:0] r_preset_q;
    logic [31:0] w_preset_d;
    logic [31:0] r_count_q;
    logic [31:0] w_count_d;
    state_e      r_state_q;
    state_e      w_state_d;
    logic        r_pending_q;
    logic        w_pending_d;

    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_auto;

    always_comb begin
        w_wr_ctrl   = WE && (Addr == c_ADDR_CTRL);
        w_wr_preset = WE && (Addr == c_ADDR_PRESET);
    end

    // Mode 1x falls back to one-shot behaviour.
    assign w_auto = (r_ctrl_q.mode == c_MODE_AUTO);

    always_comb begin
        w_ctrl_d    = r_ctrl_q;
        w_preset_d  = r_preset_q;
        w_count_d   = r_count_q;
        w_state_d   = r_state_q;
        w_pending_d = r_pending_q;

        case (r_state_q)
            ST_IDLE: begin
                if (r_ctrl_q.en) begin
                    w_state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_count_d = r_preset_q;
                w_state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!r_ctrl_q.en) begin
                    w_state_d = ST_IDLE;
                end else if (r_count_q > 32'd1) begin
                    w_count_d = r_count_q - 32'd1;
                end else begin
                    // Expiry: enable drops on INT entry so CTRL already reads
                    // disabled while the one-shot interrupt is signalled.
                    w_count_d   = 32'd0;
                    w_pending_d = 1'b1;
                    w_state_d   = ST_INT;
                    if (!w_auto) begin
                        w_ctrl_d.en = 1'b0;
                    end
                end
            end
            ST_INT: begin
                if (w_auto) begin
                    w_pending_d = 1'b0;
                    w_state_d   = ST_LOAD;
                end else begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // A software write discards every FSM action of this cycle.
        if (w_wr_ctrl || w_wr_preset) begin
            w_ctrl_d    = r_ctrl_q;
            w_count_d   = r_count_q;
            w_state_d   = ST_IDLE;
            w_pending_d = 1'b0;
            if (w_wr_ctrl) begin
                w_ctrl_d = ctrl_t'(DataIn[c_CTRL_W-1:0]);
            end
            if (w_wr_preset) begin
                w_preset_d = DataIn;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_ctrl_q    <= '0;
            r_preset_q  <= '0;
            r_count_q   <= '0;
            r_state_q   <= ST_IDLE;
            r_pending_q <= 1'b0;
        end else begin
            r_ctrl_q    <= w_ctrl_d;
            r_preset_q  <= w_preset_d;
            r_count_q   <= w_count_d;
            r_state_q   <= w_state_d;
            r_pending_q <= w_pending_d;
        end
    end

    always_comb begin
        DataOut = 32'd0;
        case (Addr)
            c_ADDR_CTRL:   DataOut = ctrl_view(r_ctrl_q);
            c_ADDR_PRESET: DataOut = r_preset_q;
            c_ADDR_COUNT:  DataOut = r_count_q;
            default:       DataOut = 32'd0;
        endcase
    end

    assign IRQ = r_ctrl_q.im & r_pending_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_dev.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_dev
//  Description : Randomised and directed bench for timer_dev, checked against
//                a closed-form timing model of the timer.
//  Revision    : 1.0
// ============================================================================
module tb_timer_dev;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        IRQ;

    int          n_vec = 0;
    int          n_err = 0;

    // Model: everything follows from the last effective write (cycle m_w).
    longint      cyc    = 0;
    longint      m_w    = 0;
    logic [3:0]  m_ctrl = 4'h0;
    logic [31:0] m_preset = 32'h0;
    logic [31:0] m_base = 32'h0;

    timer_dev dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Addr    (Addr),
        .WE      (WE),
        .DataIn  (DataIn),
        .DataOut (DataOut),
        .IRQ     (IRQ)
    );

    always #5 Clk = ~Clk;

    // k cycles after a start, with T = max(N,1): one-shot expires at k=T+2;
    // auto-reload repeats with period T+2 (T counting cycles, INT, LOAD).
    function automatic void model(output logic [31:0] cnt, output logic [3:0] ctl,
                                  output logic irq);
        longint k;
        longint t;
        longint j;
        logic   pend;
        k    = cyc - m_w;
        cnt  = m_base;
        ctl  = m_ctrl;
        pend = 1'b0;
        if (m_ctrl[0] && k >= 2) begin
            t = (m_preset == 32'd0) ? 64'sd1 : longint'({32'd0, m_preset});
            if (m_ctrl[2:1] == 2'b01) begin
                j = (k - 2) % (t + 2);
                cnt  = (j < t) ? m_preset - 32'(j) : 32'd0;
                pend = (j == t);
            end else if (k - 2 < t) begin
                cnt = m_preset - 32'(k - 2);
            end else begin
                cnt    = 32'd0;
                pend   = 1'b1;
                ctl[0] = 1'b0;
            end
        end
        irq = ctl[3] & pend;
    endfunction

    task automatic tick(input logic we, input logic [1:0] a, input logic [31:0] d);
        logic [31:0] c;
        logic [3:0]  t;
        logic        i;
        WE = we; Addr = a; DataIn = d;
        model(c, t, i);
        @(posedge Clk);
        if (we && a <= 2'd1) begin
            m_base = c;
            m_ctrl = (a == 2'd0) ? d[3:0] : t;
            if (a == 2'd1) m_preset = d;
            m_w = cyc + 1;
        end
        cyc++;
        @(negedge Clk);
        WE = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        Addr = a;
        #1;
        v = DataOut;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rd(2'd0, v); n_vec++;
        if (v !== 32'h0 || IRQ !== 1'b0) begin
            n_err++; $display("FAIL reset_hold ctrl=%h irq=%b required 0/0", v, IRQ);
        end
        Reset = 1'b0;
        m_w = cyc;
        tick(1, 2'd1, 32'd5);
        tick(1, 2'd0, 32'h9);
        repeat (4) tick(0, 2'd0, 32'h0);
        rd(2'd2, v); n_vec++;
        if (v !== 32'd3) begin
            n_err++; $display("FAIL reset_precount count=%h required 3", v);
        end
        Reset = 1'b1;
        rd(2'd2, v); n_vec++;
        if (v !== 32'h0) begin
            n_err++; $display("FAIL reset_async_count count=%h required 0", v);
        end
        rd(2'd0, v); n_vec++;
        if (v !== 32'h0 || IRQ !== 1'b0) begin
            n_err++; $display("FAIL reset_async_ctrl ctrl=%h irq=%b required 0/0", v, IRQ);
        end
        @(negedge Clk);
        Reset = 1'b0;
        m_ctrl = 4'h0; m_preset = 32'h0; m_base = 32'h0; m_w = cyc;
        tick(0, 2'd0, 32'h0);
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], v); n_vec++;
            if (v !== 32'h0) begin
                n_err++; $display("FAIL reset_release addr=%0d got %h required 0", a, v);
            end
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] v, ec;
        logic [3:0]  et;
        logic        ei;
        longint      w;
        tick(1, 2'd1, 32'd3);
        tick(1, 2'd0, 32'h9);
        w = cyc;
        repeat (26) begin
            tick(0, 2'd0, 32'h0);
            model(ec, et, ei);
            rd(2'd2, v); n_vec++;
            if (v !== ec || (cyc - w >= 2 && cyc - w <= 4 && v !== 32'(5 - (cyc - w)))) begin
                n_err++; $display("FAIL oneshot_count k=%0d got %h required %h", cyc - w, v, ec);
            end
            rd(2'd0, v); n_vec++;
            if (IRQ !== ei || (cyc - w >= 5 && (IRQ !== 1'b1 || v !== 32'h8))) begin
                n_err++; $display("FAIL oneshot_irq k=%0d irq=%b ctrl=%h required %b/%h",
                                  cyc - w, IRQ, v, ei, et);
            end
        end
        tick(1, 2'd0, 32'h8);
        n_vec++;
        if (IRQ !== 1'b0) begin
            n_err++; $display("FAIL oneshot_clear irq=%b required 0", IRQ);
        end
    endtask

    task automatic test_auto();
        logic [31:0] v, ec;
        logic [3:0]  et;
        logic        ei;
        longint      w;
        tick(1, 2'd1, 32'd2);
        tick(1, 2'd0, 32'hB);
        w = cyc;
        repeat (18) begin
            tick(0, 2'd0, 32'h0);
            model(ec, et, ei);
            n_vec++;
            if (IRQ !== (cyc - w >= 4 && (cyc - w - 4) % 4 == 0) || IRQ !== ei) begin
                n_err++; $display("FAIL auto_pulse k=%0d irq=%b required %b", cyc - w, IRQ, ei);
            end
            rd(2'd2, v); n_vec++;
            if (v !== ec) begin
                n_err++; $display("FAIL auto_count k=%0d got %h required %h", cyc - w, v, ec);
            end
        end
        tick(1, 2'd0, 32'h0);
    endtask

    task automatic test_mask();
        logic [31:0] v;
        tick(1, 2'd1, 32'd1);
        tick(1, 2'd0, 32'h1);
        repeat (6) begin
            tick(0, 2'd0, 32'h0);
            n_vec++;
            if (IRQ !== 1'b0) begin
                n_err++; $display("FAIL mask_irq irq=%b required 0", IRQ);
            end
        end
        rd(2'd2, v); n_vec++;
        if (v !== 32'h0) begin
            n_err++; $display("FAIL mask_count got %h required 0", v);
        end
        rd(2'd0, v); n_vec++;
        if (v !== 32'h0) begin
            n_err++; $display("FAIL mask_ctrl got %h required 0", v);
        end
    endtask

    task automatic test_collision();
        logic [31:0] v, ec;
        logic [3:0]  et;
        logic        ei;
        tick(1, 2'd1, 32'd3);
        tick(1, 2'd0, 32'h9);
        repeat (3) tick(0, 2'd0, 32'h0);
        tick(1, 2'd1, 32'd7);
        for (int k = 1; k <= 8; k++) begin
            model(ec, et, ei);
            rd(2'd2, v); n_vec++;
            if (IRQ !== 1'b0 || v !== ec || (k == 3 && v !== 32'd7)) begin
                n_err++; $display("FAIL collision k=%0d irq=%b count=%h required 0/%h", k, IRQ, v, ec);
            end
            tick(0, 2'd0, 32'h0);
        end
        tick(1, 2'd0, 32'h0);
    endtask

    task automatic test_bounds();
        logic [31:0] v, ec;
        logic [3:0]  et;
        logic        ei;
        tick(1, 2'd1, 32'd0);
        tick(1, 2'd0, 32'h9);
        tick(0, 2'd0, 32'h0);
        tick(0, 2'd0, 32'h0);
        n_vec++;
        if (IRQ !== 1'b0) begin
            n_err++; $display("FAIL preset0_early irq=%b required 0", IRQ);
        end
        tick(0, 2'd0, 32'h0);
        n_vec++;
        if (IRQ !== 1'b1) begin
            n_err++; $display("FAIL preset0_irq irq=%b required 1", IRQ);
        end
        tick(1, 2'd1, 32'd4);
        tick(1, 2'd0, 32'h1);
        tick(0, 2'd0, 32'h0);
        tick(1, 2'd2, 32'h55);
        tick(1, 2'd3, 32'hAA);
        model(ec, et, ei);
        rd(2'd2, v); n_vec++;
        if (v !== ec || v !== 32'd3) begin
            n_err++; $display("FAIL ignored_write count=%h required %h", v, ec);
        end
        rd(2'd3, v); n_vec++;
        if (v !== 32'h0) begin
            n_err++; $display("FAIL addr3_read got %h required 0", v);
        end
        rd(2'd1, v); n_vec++;
        if (v !== 32'd4) begin
            n_err++; $display("FAIL preset_kept got %h required 4", v);
        end
        tick(1, 2'd1, 32'hFFFF_FFFF);
        tick(1, 2'd0, 32'hFFFF_FFF1);
        rd(2'd0, v); n_vec++;
        if (v !== 32'h1) begin
            n_err++; $display("FAIL ctrl_upper got %h required 1", v);
        end
        repeat (3) tick(0, 2'd0, 32'h0);
        rd(2'd2, v); n_vec++;
        if (v !== 32'hFFFF_FFFE) begin
            n_err++; $display("FAIL max_preset got %h required fffffffe", v);
        end
        tick(1, 2'd0, 32'h0);
    endtask

    task automatic test_random();
        logic [31:0] v, ec, d;
        logic [3:0]  et;
        logic        ei;
        logic [1:0]  a;
        repeat (800) begin
            a = 2'($urandom_range(0, 3));
            d = (a == 2'd1) ? (($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, 6))
                            : $urandom;
            tick($urandom_range(0, 9) == 0, a, d);
            model(ec, et, ei);
            rd(2'd2, v); n_vec++;
            if (v !== ec) begin
                n_err++; $display("FAIL rand_count cyc=%0d got %h required %h", cyc, v, ec);
            end
            rd(2'd0, v); n_vec++;
            if (v !== {28'd0, et}) begin
                n_err++; $display("FAIL rand_ctrl cyc=%0d got %h required %h", cyc, v, et);
            end
            rd(2'd1, v); n_vec++;
            if (v !== m_preset) begin
                n_err++; $display("FAIL rand_preset cyc=%0d got %h required %h", cyc, v, m_preset);
            end
            n_vec++;
            if (IRQ !== ei) begin
                n_err++; $display("FAIL rand_irq cyc=%0d got %b required %b", cyc, IRQ, ei);
            end
        end
    endtask

    initial begin
        Reset = 1'b1; WE = 1'b0; Addr = 2'd0; DataIn = 32'h0;
        repeat (3) @(negedge Clk);
        test_reset();
        test_oneshot();
        test_auto();
        test_mask();
        test_collision();
        test_bounds();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
